// File: rtl/array_decode_pkg.sv
// -----------------------------------------------------------------------------
// array_decode_pkg
// Shared definitions for the array front end: the custom array opcode values,
// default operand/index widths and the bit positions of the instruction fields.
// The issue stage imports the same package so both ends agree on encodings.
// -----------------------------------------------------------------------------
package array_decode_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int IDXWIDTH_DEF = 5;
  localparam int OP_W         = 7;

  // Instruction field positions: op[6:0], rd[11:7], rs1[19:15], rs2[24:20]
  localparam int OP_LSB  = 0;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  localparam logic [OP_W-1:0] OPCODE_ARRAY_ADD   = 7'b1111000;
  localparam logic [OP_W-1:0] OPCODE_ARRAY_MULT  = 7'b1111001;
  localparam logic [OP_W-1:0] OPCODE_ARRAY_LOAD  = 7'b1111010;
  localparam logic [OP_W-1:0] OPCODE_ARRAY_STORE = 7'b1111011;
  localparam logic [OP_W-1:0] OPCODE_ARRAY_RELU  = 7'b1111100;

  // True when the opcode belongs to the array extension.
  function automatic logic is_array_op(input logic [OP_W-1:0] opc);
    logic hit;
    case (opc)
      OPCODE_ARRAY_ADD,
      OPCODE_ARRAY_MULT,
      OPCODE_ARRAY_LOAD,
      OPCODE_ARRAY_STORE,
      OPCODE_ARRAY_RELU: hit = 1'b1;
      default:           hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/array_decode_scalar_regfile.sv
// -----------------------------------------------------------------------------
// array_decode_scalar_regfile
// 2**IDXWIDTH x WIDTH scalar register file: two asynchronous read ports, one
// synchronous write port, register 0 hardwired to zero, and a write-to-read
// bypass so a read sees wb_data in the same cycle it is being written.
// Ports:
//   CLK, RST              clock / async active-low reset (clears every entry)
//   wb_en, wb_idx, wb_data write port (writes to index 0 are ignored)
//   ra1, ra2              read indices
//   rd1, rd2              read data
// -----------------------------------------------------------------------------
module array_decode_scalar_regfile #(
  parameter int WIDTH    = 32,
  parameter int IDXWIDTH = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                wb_en,
  input  logic [IDXWIDTH-1:0] wb_idx,
  input  logic [WIDTH-1:0]    wb_data,
  input  logic [IDXWIDTH-1:0] ra1,
  input  logic [IDXWIDTH-1:0] ra2,
  output logic [WIDTH-1:0]    rd1,
  output logic [WIDTH-1:0]    rd2
);

  localparam int NREG = 2**IDXWIDTH;

  logic [WIDTH-1:0] regs_r [NREG];
  logic             wr_s;

  // Qualified write strobe: index 0 is never written.
  always_comb begin
    wr_s = wb_en && (wb_idx != {IDXWIDTH{1'b0}});
  end

  // Register storage with async clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_s) begin
      regs_r[wb_idx] <= wb_data;
    end
  end

  // Read port 1: zero register, then bypass from the write port, then storage.
  always_comb begin
    if (ra1 == {IDXWIDTH{1'b0}}) begin
      rd1 = {WIDTH{1'b0}};
    end else if (wr_s && (wb_idx == ra1)) begin
      rd1 = wb_data;
    end else begin
      rd1 = regs_r[ra1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    if (ra2 == {IDXWIDTH{1'b0}}) begin
      rd2 = {WIDTH{1'b0}};
    end else if (wr_s && (wb_idx == ra2)) begin
      rd2 = wb_data;
    end else begin
      rd2 = regs_r[ra2];
    end
  end

endmodule

// File: rtl/array_decode.sv
// -----------------------------------------------------------------------------
// array_decode
// Front end of the array pipeline. Accepts 32-bit instruction words over a
// valid/ready handshake, keeps only array opcodes, queues {op, rd, rs1, rs2}
// in a small FIFO and presents the head to issue with its two scalar operands
// read from the internal register file at dequeue time.
// Ports:
//   CLK, RST                   clock / async active-low reset
//   inst, inst_valid, inst_ready  instruction input handshake
//   wb_en, wb_idx, wb_data     scalar register writeback
//   op, rd, rs1, rs2           head-of-queue decoded fields
//   regval1, regval2           scalar values of rs1 / rs2 (with write bypass)
//   valid, busy                output handshake (busy = issue cannot accept)
//   drop                       one-cycle pulse: accepted word was not an array op
// -----------------------------------------------------------------------------
module array_decode
  import array_decode_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int IDXWIDTH   = IDXWIDTH_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [31:0]         inst,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic                wb_en,
  input  logic [IDXWIDTH-1:0] wb_idx,
  input  logic [WIDTH-1:0]    wb_data,
  output logic [OP_W-1:0]     op,
  output logic [IDXWIDTH-1:0] rd,
  output logic [IDXWIDTH-1:0] rs1,
  output logic [IDXWIDTH-1:0] rs2,
  output logic [WIDTH-1:0]    regval1,
  output logic [WIDTH-1:0]    regval2,
  output logic                valid,
  input  logic                busy,
  output logic                drop
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(FIFO_DEPTH);

  logic [OP_W-1:0]     op_mem_r  [FIFO_DEPTH];
  logic [IDXWIDTH-1:0] rd_mem_r  [FIFO_DEPTH];
  logic [IDXWIDTH-1:0] rs1_mem_r [FIFO_DEPTH];
  logic [IDXWIDTH-1:0] rs2_mem_r [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          valid_r;
  logic          inst_ready_r;
  logic          drop_r;

  logic [OP_W-1:0] inst_op_s;
  logic            is_array_s;
  logic            accept_s;
  logic            push_s;
  logic            pop_s;
  logic            unused_inst_s;

  // Instruction bits outside the decoded fields carry no meaning here.
  assign unused_inst_s = ^inst;

  // Handshake qualification: what is accepted, enqueued and popped this cycle.
  always_comb begin
    inst_op_s  = inst[OP_LSB +: OP_W];
    is_array_s = is_array_op(inst_op_s);
    accept_s   = inst_valid && inst_ready_r;
    push_s     = accept_s && is_array_s;
    pop_s      = valid_r && !busy;
  end

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, pointers and registered status flags.
  // inst_ready is computed from the post-edge occupancy, so a full queue
  // stays not-ready on the cycle it pops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        op_mem_r[i]  <= {OP_W{1'b0}};
        rd_mem_r[i]  <= {IDXWIDTH{1'b0}};
        rs1_mem_r[i] <= {IDXWIDTH{1'b0}};
        rs2_mem_r[i] <= {IDXWIDTH{1'b0}};
      end
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      valid_r      <= 1'b0;
      inst_ready_r <= 1'b0;
      drop_r       <= 1'b0;
    end else begin
      if (push_s) begin
        op_mem_r[wr_ptr_r]  <= inst_op_s;
        rd_mem_r[wr_ptr_r]  <= inst[RD_LSB  +: IDXWIDTH];
        rs1_mem_r[wr_ptr_r] <= inst[RS1_LSB +: IDXWIDTH];
        rs2_mem_r[wr_ptr_r] <= inst[RS2_LSB +: IDXWIDTH];
        wr_ptr_r            <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r      <= count_next_s;
      valid_r      <= (count_next_s != {CW{1'b0}});
      inst_ready_r <= (count_next_s < CNT_DEPTH);
      drop_r       <= accept_s && !is_array_s;
    end
  end

  // Head fields; an empty queue presents zeros so stale slots never leak out.
  always_comb begin
    if (valid_r) begin
      op  = op_mem_r[rd_ptr_r];
      rd  = rd_mem_r[rd_ptr_r];
      rs1 = rs1_mem_r[rd_ptr_r];
      rs2 = rs2_mem_r[rd_ptr_r];
    end else begin
      op  = {OP_W{1'b0}};
      rd  = {IDXWIDTH{1'b0}};
      rs1 = {IDXWIDTH{1'b0}};
      rs2 = {IDXWIDTH{1'b0}};
    end
  end

  assign valid      = valid_r;
  assign inst_ready = inst_ready_r;
  assign drop       = drop_r;

  // Operands are read at the head's indices every cycle, so writes landing
  // while the entry waits in the queue are seen at transfer time.
  array_decode_scalar_regfile #(
    .WIDTH    (WIDTH),
    .IDXWIDTH (IDXWIDTH)
  ) u_regfile (
    .CLK     (CLK),
    .RST     (RST),
    .wb_en   (wb_en),
    .wb_idx  (wb_idx),
    .wb_data (wb_data),
    .ra1     (rs1),
    .ra2     (rs2),
    .rd1     (regval1),
    .rd2     (regval2)
  );

endmodule

// File: tb/tb_array_decode.sv
module tb_array_decode;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        wb_en;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] regval1, regval2;
  logic        valid;
  logic        busy;
  logic        drop;

  always #5 CLK = ~CLK;

  array_decode dut (
    .CLK(CLK), .RST(RST),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .regval1(regval1), .regval2(regval2),
    .valid(valid), .busy(busy), .drop(drop)
  );

  typedef struct {
    logic [6:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ent_t;

  // Reference model state
  ent_t        exp_q[$];
  logic [31:0] mregs [32];
  bit          ready_seen  = 1'b0;
  bit          exp_ready_l = 1'b0;
  bit          exp_drop    = 1'b0;
  ent_t        mon_h;

  int checks = 0;
  int fails  = 0;

  localparam logic [6:0] ADD   = 7'd120;
  localparam logic [6:0] MULT  = 7'd121;
  localparam logic [6:0] LOAD  = 7'd122;
  localparam logic [6:0] STORE = 7'd123;
  localparam logic [6:0] RELU  = 7'd124;

  // Array opcodes are the contiguous range 120..124.
  function automatic bit model_is_array(input logic [6:0] o);
    return (o >= 7'd120) && (o <= 7'd124);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_idx == idx) return wb_data;
    return mregs[idx];
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] o, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2);
    return {7'd0, s2, s1, 3'd0, d, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Model update at each rising edge: acceptance, enqueue, drop, regfile writes.
  always @(posedge CLK) begin
    if (!RST) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      ready_seen = 1'b0;
      exp_drop   = 1'b0;
    end else begin
      if (inst_valid && exp_ready_l) begin
        if (model_is_array(inst[6:0]))
          exp_q.push_back('{op: inst[6:0], rd: inst[11:7], rs1: inst[19:15], rs2: inst[24:20]});
        exp_drop = !model_is_array(inst[6:0]);
      end else begin
        exp_drop = 1'b0;
      end
      if (wb_en && wb_idx != 5'd0) mregs[wb_idx] = wb_data;
      ready_seen = 1'b1;
    end
  end

  // Monitor: compares DUT outputs with the model mid-cycle, pops on transfer.
  always @(negedge CLK) begin
    if (!RST) begin
      exp_q.delete();
      exp_ready_l = 1'b0;
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
      chk("rst_drop", {31'd0, drop}, 32'd0);
      chk("rst_op", {25'd0, op}, 32'd0);
      chk("rst_regval1", regval1, 32'd0);
      chk("rst_regval2", regval2, 32'd0);
    end else begin
      exp_ready_l = ready_seen && (exp_q.size() < 2);
      chk("valid", {31'd0, valid}, {31'd0, exp_q.size() != 0});
      chk("inst_ready", {31'd0, inst_ready}, {31'd0, exp_ready_l});
      chk("drop", {31'd0, drop}, {31'd0, exp_drop});
      if (exp_q.size() != 0) begin
        mon_h = exp_q[0];
        chk("op", {25'd0, op}, {25'd0, mon_h.op});
        chk("rd", {27'd0, rd}, {27'd0, mon_h.rd});
        chk("rs1", {27'd0, rs1}, {27'd0, mon_h.rs1});
        chk("rs2", {27'd0, rs2}, {27'd0, mon_h.rs2});
        chk("regval1", regval1, model_read(mon_h.rs1));
        chk("regval2", regval2, model_read(mon_h.rs2));
        if (!busy) void'(exp_q.pop_front());
      end else begin
        chk("idle_op", {25'd0, op}, 32'd0);
        chk("idle_regval1", regval1, 32'd0);
        chk("idle_regval2", regval2, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a word and hold it until the DUT takes it (bounded).
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    inst       = w;
    inst_valid = 1'b1;
    while (!inst_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: inst_ready stayed %b, required 1", inst_ready);
    end
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic wb(input logic en, input logic [4:0] idx, input logic [31:0] d);
    wb_en   = en;
    wb_idx  = idx;
    wb_data = d;
  endtask

  initial begin
    int n;
    logic [31:0] w;
    RST = 1'b1; inst = 32'd0; inst_valid = 1'b0; busy = 1'b0;
    wb_en = 1'b0; wb_idx = 5'd0; wb_data = 32'd0;
    #1 RST = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    tick();

    // Basic decode with a previously written x1
    wb(1'b1, 5'd1, 32'h20); tick(); wb(1'b0, 5'd0, 32'd0);
    send(mk(ADD, 5'd2, 5'd0, 5'd1));
    repeat (2) tick();

    // Backpressure: two queued, third stalls, then in-order drain
    busy = 1'b1;
    send(mk(ADD, 5'd3, 5'd1, 5'd2));
    send(mk(MULT, 5'd4, 5'd2, 5'd1));
    inst = mk(RELU, 5'd5, 5'd1, 5'd1); inst_valid = 1'b1;
    repeat (3) tick();
    busy = 1'b0;
    send(mk(RELU, 5'd5, 5'd1, 5'd1));
    repeat (3) tick();

    // Non-array opcode is dropped
    send(mk(7'b0110011, 5'd1, 5'd2, 5'd3));
    repeat (3) tick();

    // Late write and same-cycle bypass while queued
    busy = 1'b1;
    send(mk(LOAD, 5'd3, 5'd5, 5'd0));
    wb(1'b1, 5'd5, 32'h8); tick();
    wb(1'b0, 5'd0, 32'd0); tick();
    wb(1'b1, 5'd5, 32'h10); busy = 1'b0; tick();
    wb(1'b0, 5'd0, 32'd0);
    busy = 1'b1;
    send(mk(STORE, 5'd1, 5'd0, 5'd5));
    wb(1'b1, 5'd0, 32'hFFFF_FFFF); busy = 1'b0; tick();
    wb(1'b0, 5'd0, 32'd0);
    repeat (2) tick();

    // Back-to-back stream across pointer wrap
    for (int i = 0; i < 10; i++) begin
      send(mk(7'd120 + 7'(i % 5), 5'(i), 5'(i + 1), 5'(31 - i)));
    end
    repeat (3) tick();

    // Reset with two entries queued
    busy = 1'b1;
    send(mk(ADD, 5'd1, 5'd1, 5'd5));
    send(mk(MULT, 5'd2, 5'd5, 5'd1));
    RST = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    tick();
    busy = 1'b0;
    send(mk(ADD, 5'd7, 5'd5, 5'd1));
    repeat (2) tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) < 8) w[6:0] = 7'd120 + 7'($urandom_range(0, 4));
      inst       = w;
      inst_valid = ($urandom_range(0, 3) != 0);
      busy       = ($urandom_range(0, 3) == 0);
      wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      tick();
    end

    // Drain
    inst_valid = 1'b0; busy = 1'b0; wb(1'b0, 5'd0, 32'd0);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
